gpio_core_irq: RTL and testbench

- Parametrised GPIO core with WIDTH pins, a per-pin direction register and per-pin interrupt logic.
- Interrupts are sticky, write-1-to-clear and individually enabled; each pin selects level or edge mode and active polarity.
- Inputs pass through a 2-flop synchroniser.
- Sits behind the same simple register bus as the existing GPIO core: one write port, one read port, registered read data and error flag.

---
 rtl/gpio_core_pkg.sv | 21 ++
 rtl/gpio_irq_bit.sv | 54 +++++
 rtl/gpio_core_irq.sv | 127 ++++++++++++
 tb/tb_gpio_core_irq.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_core_pkg.sv
// Shared register map, interrupt-mode encoding and limits for the GPIO core
// with per-pin interrupts.
package gpio_core_pkg;

  localparam int WIDTH_MAX = 32;

  // Register word indices.
  localparam int DAT   = 0;
  localparam int DIR   = 1;
  localparam int IEN   = 2;
  localparam int ISTAT = 3;
  localparam int IMODE = 4;
  localparam int IPOL  = 5;
  localparam int PIN   = 6;

  typedef enum logic {
    IMODE_LEVEL = 1'b0,
    IMODE_EDGE  = 1'b1
  } imode_e;

endpackage

// File: rtl/gpio_irq_bit.sv
// Per-pin input synchroniser, edge history and sticky W1C interrupt status bit.
module gpio_irq_bit
  import gpio_core_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   pin_i,
  input  logic   dir_i,
  input  imode_e mode_i,
  input  logic   pol_i,
  input  logic   clr_i,
  input  logic   arm_i,
  output logic   sync_o,
  output logic   stat_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   stat_q;
  logic                   stat_d;
  logic                   active;
  logic                   active_prev;
  logic                   cond;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      stat_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      stat_q <= stat_d;
    end
  end

  // Polarity folds low/falling onto high/rising so one detector serves both.
  always_comb begin
    active      = sync_q[SYNC_STAGES-1] ^ pol_i;
    active_prev = prev_q ^ pol_i;
    cond        = 1'b0;
    if (dir_i) begin
      if (mode_i == IMODE_EDGE) cond = active & ~active_prev & arm_i;
      else                      cond = active;
    end
    stat_d = cond | (stat_q & ~clr_i);
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign stat_o = stat_q;

endmodule

// File: rtl/gpio_core_irq.sv
// GPIO core with direction control and per-pin level/edge interrupts behind a
// simple one-write-port / one-read-port register bus.
module gpio_core_irq
  import gpio_core_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int ADR_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic [ADR_W-1:0] iWADR,
  input  logic             iWR,
  input  logic [31:0]      iWDAT,
  input  logic [ADR_W-1:0] iRADR,
  output logic [31:0]      oRDAT,
  input  logic [WIDTH-1:0] iGPIN,
  output logic [WIDTH-1:0] oGPOUT,
  output logic [WIDTH-1:0] oGPOE,
  output logic             oINT,
  output logic             oERR
);

  localparam int ARM_N = SYNC_STAGES + 1;
  localparam int CNT_W = $clog2(ARM_N + 1);

  logic [ADR_W-1:0] adr;
  logic [WIDTH-1:0] wdat;
  logic [WIDTH-1:0] dat_q, dat_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] ien_q, ien_d;
  logic [WIDTH-1:0] imode_q, imode_d;
  logic [WIDTH-1:0] ipol_q, ipol_d;
  logic [WIDTH-1:0] istat;
  logic [WIDTH-1:0] pin_sync;
  logic [WIDTH-1:0] clr;
  logic [CNT_W-1:0] arm_cnt_q, arm_cnt_d;
  logic             arm;
  logic [31:0]      rdat_q, rdat_d;
  logic             err_q, err_d;

  assign adr  = iWR ? iWADR : iRADR;
  assign wdat = iWDAT[WIDTH-1:0];
  assign arm  = (arm_cnt_q == CNT_W'(ARM_N));

  always_comb begin
    dat_d     = dat_q;
    dir_d     = dir_q;
    ien_d     = ien_q;
    imode_d   = imode_q;
    ipol_d    = ipol_q;
    clr       = '0;
    err_d     = 1'b0;
    rdat_d    = '0;
    arm_cnt_d = arm ? arm_cnt_q : arm_cnt_q + CNT_W'(1);

    // Read data always reflects the pre-write contents of the selected word.
    case (adr)
      ADR_W'(DAT):   rdat_d[WIDTH-1:0] = dat_q;
      ADR_W'(DIR):   rdat_d[WIDTH-1:0] = dir_q;
      ADR_W'(IEN):   rdat_d[WIDTH-1:0] = ien_q;
      ADR_W'(ISTAT): rdat_d[WIDTH-1:0] = istat;
      ADR_W'(IMODE): rdat_d[WIDTH-1:0] = imode_q;
      ADR_W'(IPOL):  rdat_d[WIDTH-1:0] = ipol_q;
      ADR_W'(PIN):   rdat_d[WIDTH-1:0] = pin_sync;
      default:       rdat_d = '0;
    endcase

    if (iWR) begin
      case (adr)
        ADR_W'(DAT):   dat_d   = wdat & ~dir_q;
        ADR_W'(DIR):   dir_d   = wdat;
        ADR_W'(IEN):   ien_d   = wdat;
        ADR_W'(ISTAT): clr     = wdat;
        ADR_W'(IMODE): imode_d = wdat;
        ADR_W'(IPOL):  ipol_d  = wdat;
        default:       err_d   = 1'b1;
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      dat_q     <= '0;
      dir_q     <= '0;
      ien_q     <= '0;
      imode_q   <= '0;
      ipol_q    <= '0;
      arm_cnt_q <= '0;
      rdat_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      dat_q     <= dat_d;
      dir_q     <= dir_d;
      ien_q     <= ien_d;
      imode_q   <= imode_d;
      ipol_q    <= ipol_d;
      arm_cnt_q <= arm_cnt_d;
      rdat_q    <= rdat_d;
      err_q     <= err_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpio_irq_bit #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_bit (
      .clk_i (iCLK),
      .rst_i (iRST),
      .pin_i (iGPIN[i]),
      .dir_i (dir_q[i]),
      .mode_i(imode_e'(imode_q[i])),
      .pol_i (ipol_q[i]),
      .clr_i (clr[i]),
      .arm_i (arm),
      .sync_o(pin_sync[i]),
      .stat_o(istat[i])
    );
  end

  assign oRDAT  = rdat_q;
  assign oERR   = err_q;
  assign oGPOUT = dat_q & ~dir_q;
  assign oGPOE  = ~dir_q;
  assign oINT   = |(istat & ien_q & dir_q);

endmodule

// File: tb/tb_gpio_core_irq.sv
// Directed bench for gpio_core_irq: register access, errors, edge/level
// interrupts, W1C behaviour and start-up edge suppression.
module tb_gpio_core_irq;

  localparam int WIDTH = 32;
  localparam int ADR_W = 8;

  logic             iCLK;
  logic             iRST;
  logic [ADR_W-1:0] iWADR;
  logic             iWR;
  logic [31:0]      iWDAT;
  logic [ADR_W-1:0] iRADR;
  logic [31:0]      oRDAT;
  logic [WIDTH-1:0] iGPIN;
  logic [WIDTH-1:0] oGPOUT;
  logic [WIDTH-1:0] oGPOE;
  logic             oINT;
  logic             oERR;

  int errors = 0;
  int checks = 0;

  gpio_core_irq #(
    .WIDTH(WIDTH),
    .ADR_W(ADR_W),
    .SYNC_STAGES(2)
  ) dut (
    .iCLK  (iCLK),
    .iRST  (iRST),
    .iWADR (iWADR),
    .iWR   (iWR),
    .iWDAT (iWDAT),
    .iRADR (iRADR),
    .oRDAT (oRDAT),
    .iGPIN (iGPIN),
    .oGPOUT(oGPOUT),
    .oGPOE (oGPOE),
    .oINT  (oINT),
    .oERR  (oERR)
  );

  // Clock and reset defaults.
  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [ADR_W-1:0] a, input logic [31:0] d);
    iWR   = 1'b1;
    iWADR = a;
    iWDAT = d;
    tick();
    iWR   = 1'b0;
  endtask

  task automatic rd(input logic [ADR_W-1:0] a, output logic [31:0] d);
    iRADR = a;
    tick();
    d = oRDAT;
  endtask

  initial begin
    logic [31:0] r;
    logic        err_seen;

    iRST  = 1'b1;
    iWR   = 1'b0;
    iWADR = '0;
    iWDAT = '0;
    iRADR = '0;
    iGPIN = '0;
    repeat (3) tick();
    iRST = 1'b0;

    // Reset state.
    check("rst_rdat", oRDAT, 32'h0);
    check("rst_oe", oGPOE, 32'hFFFF_FFFF);
    check("rst_out", oGPOUT, 32'h0);
    check("rst_int", {31'b0, oINT}, 32'h0);
    check("rst_err", {31'b0, oERR}, 32'h0);
    err_seen = 1'b0;
    for (int a = 0; a < 8; a++) begin
      rd(ADR_W'(a), r);
      err_seen |= oERR;
      check($sformatf("rst_rd%0d", a), r, 32'h0);
    end
    check("rd_no_err", {31'b0, err_seen}, 32'h0);

    // Direction masking of DAT and outputs.
    wr(ADR_W'(1), 32'h0000_00F0);
    wr(ADR_W'(0), 32'hFFFF_FFFF);
    check("wr_no_err", {31'b0, oERR}, 32'h0);
    check("gpout", oGPOUT, 32'hFFFF_FF0F);
    check("gpoe", oGPOE, 32'hFFFF_FF0F);
    rd(ADR_W'(0), r);
    check("dat_rd", r, 32'hFFFF_FF0F);

    // Simultaneous write and read: pre-write contents of the write address.
    iRADR = ADR_W'(1);
    wr(ADR_W'(0), 32'h0);
    check("wr_rd_pre", oRDAT, 32'hFFFF_FF0F);
    rd(ADR_W'(0), r);
    check("dat_after", r, 32'h0);

    // Rising edge interrupt on pin 0.
    wr(ADR_W'(1), 32'h1);
    wr(ADR_W'(4), 32'h1);
    wr(ADR_W'(5), 32'h0);
    wr(ADR_W'(2), 32'h1);
    iRADR = ADR_W'(3);
    iGPIN = 32'h1;
    tick();
    tick();
    check("edge_int_early", {31'b0, oINT}, 32'h0);
    tick();
    tick();
    check("edge_int", {31'b0, oINT}, 32'h1);
    check("edge_istat", oRDAT, 32'h1);
    wr(ADR_W'(3), 32'h1);
    check("w1c_int", {31'b0, oINT}, 32'h0);
    rd(ADR_W'(3), r);
    check("w1c_istat", r, 32'h0);
    repeat (3) tick();
    rd(ADR_W'(3), r);
    check("w1c_stays", r, 32'h0);

    // Level-low interrupt on pin 3: W1C ineffective while the level persists.
    wr(ADR_W'(1), 32'h8);
    wr(ADR_W'(4), 32'h0);
    wr(ADR_W'(5), 32'h8);
    tick();
    tick();
    rd(ADR_W'(3), r);
    check("lvl_set", r, 32'h8);
    check("lvl_int_gated", {31'b0, oINT}, 32'h0);
    wr(ADR_W'(2), 32'h8);
    check("lvl_int", {31'b0, oINT}, 32'h1);
    wr(ADR_W'(3), 32'h8);
    rd(ADR_W'(3), r);
    check("lvl_w1c_held", r, 32'h8);
    iGPIN = 32'h9;
    repeat (3) tick();
    rd(ADR_W'(3), r);
    check("lvl_sticky", r, 32'h8);
    wr(ADR_W'(3), 32'h8);
    rd(ADR_W'(3), r);
    check("lvl_cleared", r, 32'h0);
    check("lvl_int_off", {31'b0, oINT}, 32'h0);

    // Error pulses on writes to PIN and to an unmapped word.
    wr(ADR_W'(6), 32'hFFFF_FFFF);
    check("err_pin", {31'b0, oERR}, 32'h1);
    tick();
    check("err_pin_pulse", {31'b0, oERR}, 32'h0);
    wr(ADR_W'(8'h20), 32'hFFFF_FFFF);
    check("err_unmap", {31'b0, oERR}, 32'h1);
    tick();
    check("err_unmap_pulse", {31'b0, oERR}, 32'h0);
    rd(ADR_W'(6), r);
    check("pin_val", r, 32'h9);
    rd(ADR_W'(0), r);
    check("err_dat", r, 32'h0);
    rd(ADR_W'(1), r);
    check("err_dir", r, 32'h8);
    rd(ADR_W'(2), r);
    check("err_ien", r, 32'h8);
    rd(ADR_W'(4), r);
    check("err_imode", r, 32'h0);
    rd(ADR_W'(5), r);
    check("err_ipol", r, 32'h8);
    rd(ADR_W'(8'h20), r);
    check("unmap_rd", r, 32'h0);

    // Pins held high through reset release: no start-up edge may latch.
    iGPIN = 32'hFFFF_FFFF;
    iRST  = 1'b1;
    repeat (2) tick();
    iWR   = 1'b1;
    iWADR = ADR_W'(1);
    iWDAT = 32'hFFFF_FFFF;
    iRST  = 1'b0;
    tick();
    iWADR = ADR_W'(4);
    tick();
    iWADR = ADR_W'(2);
    tick();
    iWR = 1'b0;
    repeat (4) tick();
    rd(ADR_W'(3), r);
    check("arm_no_istat", r, 32'h0);
    check("arm_no_int", {31'b0, oINT}, 32'h0);

    // Raise an interrupt, then reset mid-interrupt.
    iGPIN = 32'h0;
    repeat (4) tick();
    iGPIN = 32'h1;
    repeat (4) tick();
    rd(ADR_W'(3), r);
    check("rearm_istat", r, 32'h1);
    check("rearm_int", {31'b0, oINT}, 32'h1);
    iRST = 1'b1;
    tick();
    check("midrst_int", {31'b0, oINT}, 32'h0);
    check("midrst_oe", oGPOE, 32'hFFFF_FFFF);
    iRST = 1'b0;
    rd(ADR_W'(3), r);
    check("midrst_istat", r, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
